// File: rtl/ul_frame_sequencer_pkg.sv
// Shared types and constants for the uplink frame sequencer.
//   ul_seq_state_t  : sequencer FSM state encoding (4 bits, nine states)
//   UL_BURST_BYTES  : default payload bytes per data burst
//   UL_MAX_RETRY    : default uncorrectable-header budget before lockout
//   is_wait_state() : true for the four states guarded by the watchdog
package ul_frame_sequencer_pkg;

  localparam int UL_BURST_BYTES = 7;
  localparam int UL_MAX_RETRY   = 3;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_TRAIN_START = 4'd1,
    ST_TRAIN_WAIT  = 4'd2,
    ST_HDR_START   = 4'd3,
    ST_HDR_WAIT    = 4'd4,
    ST_FEC_WAIT    = 4'd5,
    ST_DATA_START  = 4'd6,
    ST_DATA_WAIT   = 4'd7,
    ST_LOCKOUT     = 4'd8
  } ul_seq_state_t;

  function automatic logic is_wait_state(input ul_seq_state_t s);
    return (s == ST_TRAIN_WAIT) || (s == ST_HDR_WAIT) ||
           (s == ST_FEC_WAIT)   || (s == ST_DATA_WAIT);
  endfunction

endpackage

// File: rtl/ul_frame_sequencer_watchdog.sv
// Per-wait watchdog counter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : reload from timeout_i (entry into a wait state)
//   run_i        : currently in a wait state; count down
//   timeout_i    : reload value; 0 leaves the counter at 0 so it never expires
//   expire_o     : this cycle is the one in which the count reaches 0
module ul_watchdog #(
  parameter int TO_WIDTH = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                run_i,
  input  logic [TO_WIDTH-1:0] timeout_i,
  output logic                expire_o
);

  logic [TO_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                          cnt_q <= '0;
    else if (load_i)                    cnt_q <= timeout_i;
    else if (run_i && (cnt_q != '0))    cnt_q <= cnt_q - 1'b1;
  end

  // A load of N gives exactly N cycles in the wait state; expiry fires on
  // the Nth, when the count steps from 1 to 0. A load of 0 never matches.
  assign expire_o = run_i && (cnt_q == {{(TO_WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/ul_frame_sequencer.sv
// Uplink frame sequencer: training detect -> header deserialise -> FEC
// verdict -> burst-wise payload deserialise, with watchdog, bounded retry
// with lockout, and saturating statistics.
//   clk, rst, enable, cfg_timeout          : clock/reset/control
//   train_start/train_done                  : training detector handshake
//   deser_start/deser_hdr/deser_done        : deserializer handshake
//   fec_done/fec_uncor_err/hdr_len          : FEC header verdict
//   msg_cnt, burst_valid, burst_hdr         : burst delivery
//   frame_done, lockout, busy               : status
//   frame_ok_cnt/fec_err_cnt/timeout_cnt    : saturating statistics
module ul_frame_sequencer
  import ul_frame_sequencer_pkg::*;
#(
  parameter int LEN_WIDTH   = 8,
  parameter int BURST_BYTES = UL_BURST_BYTES,
  parameter int TO_WIDTH    = 16,
  parameter int STAT_WIDTH  = 8,
  parameter int MAX_RETRY   = UL_MAX_RETRY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [TO_WIDTH-1:0]   cfg_timeout,
  output logic                  train_start,
  input  logic                  train_done,
  output logic                  deser_start,
  output logic                  deser_hdr,
  input  logic                  deser_done,
  input  logic                  fec_done,
  input  logic                  fec_uncor_err,
  input  logic [LEN_WIDTH-1:0]  hdr_len,
  output logic [LEN_WIDTH-1:0]  msg_cnt,
  output logic                  burst_valid,
  output logic                  burst_hdr,
  output logic                  frame_done,
  output logic                  lockout,
  output logic                  busy,
  output logic [STAT_WIDTH-1:0] frame_ok_cnt,
  output logic [STAT_WIDTH-1:0] fec_err_cnt,
  output logic [STAT_WIDTH-1:0] timeout_cnt
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [LEN_WIDTH:0] BURST_EXT = (LEN_WIDTH+1)'(BURST_BYTES);

  ul_seq_state_t         state_q, state_d;
  logic                  expect_hdr_q, expect_hdr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  msg_cnt_q, msg_cnt_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic                  burst_valid_q, burst_valid_d;
  logic                  burst_hdr_q, burst_hdr_d;
  logic                  frame_done_q, frame_done_d;
  logic [STAT_WIDTH-1:0] frame_ok_q, frame_ok_d;
  logic [STAT_WIDTH-1:0] fec_err_q, fec_err_d;
  logic [STAT_WIDTH-1:0] timeout_q, timeout_d;

  logic                  wd_load, wd_run, wd_expire;
  logic                  abort;
  logic                  frame_end;
  logic [LEN_WIDTH:0]    msg_sum;

  // One extra bit so a burst step past the length clamps instead of wrapping.
  assign msg_sum = {1'b0, msg_cnt_q} + BURST_EXT;

  assign wd_run  = is_wait_state(state_q);
  assign wd_load = is_wait_state(state_d) && (state_d != state_q);

  ul_watchdog #(.TO_WIDTH(TO_WIDTH)) u_wd (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (wd_load),
    .run_i     (wd_run),
    .timeout_i (cfg_timeout),
    .expire_o  (wd_expire)
  );

  always_comb begin
    state_d       = state_q;
    expect_hdr_d  = expect_hdr_q;
    len_d         = len_q;
    msg_cnt_d     = msg_cnt_q;
    retry_d       = retry_q;
    burst_valid_d = 1'b0;
    burst_hdr_d   = 1'b0;
    frame_done_d  = 1'b0;
    frame_ok_d    = frame_ok_q;
    fec_err_d     = fec_err_q;
    timeout_d     = timeout_q;
    abort         = 1'b0;
    frame_end     = 1'b0;

    if (!enable) begin
      state_d      = ST_IDLE;
      expect_hdr_d = 1'b1;
      msg_cnt_d    = '0;
      retry_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE:        state_d = ST_TRAIN_START;
        ST_TRAIN_START: state_d = ST_TRAIN_WAIT;
        ST_TRAIN_WAIT: begin
          if (train_done) begin
            if (expect_hdr_q) begin
              state_d = ST_HDR_START;
            end else begin
              state_d   = ST_DATA_START;
              msg_cnt_d = (msg_sum > {1'b0, len_q}) ? len_q : msg_sum[LEN_WIDTH-1:0];
            end
          end else if (wd_expire) begin
            abort = 1'b1;
          end
        end
        ST_HDR_START:   state_d = ST_HDR_WAIT;
        ST_HDR_WAIT: begin
          if (deser_done) begin
            state_d       = ST_FEC_WAIT;
            burst_valid_d = 1'b1;
            burst_hdr_d   = 1'b1;
          end else if (wd_expire) begin
            abort = 1'b1;
          end
        end
        ST_FEC_WAIT: begin
          if (fec_done) begin
            if (fec_uncor_err) begin
              if (~&fec_err_q) fec_err_d = fec_err_q + 1'b1;
              retry_d = retry_q + 1'b1;
              if (int'(retry_q) + 1 >= MAX_RETRY) begin
                state_d = ST_LOCKOUT;
              end else begin
                state_d      = ST_TRAIN_START;
                expect_hdr_d = 1'b1;
              end
            end else begin
              len_d     = hdr_len;
              msg_cnt_d = '0;
              state_d   = ST_TRAIN_START;
              if (hdr_len == '0) begin
                frame_end = 1'b1;
              end else begin
                expect_hdr_d = 1'b0;
              end
            end
          end else if (wd_expire) begin
            abort = 1'b1;
          end
        end
        ST_DATA_START:  state_d = ST_DATA_WAIT;
        ST_DATA_WAIT: begin
          if (deser_done) begin
            state_d       = ST_TRAIN_START;
            burst_valid_d = 1'b1;
            if (msg_cnt_q >= len_q) begin
              frame_end = 1'b1;
              msg_cnt_d = '0;
            end else begin
              expect_hdr_d = 1'b0;
            end
          end else if (wd_expire) begin
            abort = 1'b1;
          end
        end
        ST_LOCKOUT:     state_d = ST_LOCKOUT;
        default:        state_d = ST_IDLE;
      endcase

      if (frame_end) begin
        frame_done_d = 1'b1;
        expect_hdr_d = 1'b1;
        retry_d      = '0;
        if (~&frame_ok_q) frame_ok_d = frame_ok_q + 1'b1;
      end

      if (abort) begin
        state_d      = ST_TRAIN_START;
        expect_hdr_d = 1'b1;
        msg_cnt_d    = '0;
        if (~&timeout_q) timeout_d = timeout_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      expect_hdr_q  <= 1'b1;
      len_q         <= '0;
      msg_cnt_q     <= '0;
      retry_q       <= '0;
      burst_valid_q <= 1'b0;
      burst_hdr_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_ok_q    <= '0;
      fec_err_q     <= '0;
      timeout_q     <= '0;
    end else begin
      state_q       <= state_d;
      expect_hdr_q  <= expect_hdr_d;
      len_q         <= len_d;
      msg_cnt_q     <= msg_cnt_d;
      retry_q       <= retry_d;
      burst_valid_q <= burst_valid_d;
      burst_hdr_q   <= burst_hdr_d;
      frame_done_q  <= frame_done_d;
      frame_ok_q    <= frame_ok_d;
      fec_err_q     <= fec_err_d;
      timeout_q     <= timeout_d;
    end
  end

  assign train_start  = (state_q == ST_TRAIN_START);
  assign deser_start  = (state_q == ST_HDR_START) || (state_q == ST_DATA_START);
  assign deser_hdr    = (state_q == ST_HDR_START);
  assign lockout      = (state_q == ST_LOCKOUT);
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_LOCKOUT);
  assign msg_cnt      = msg_cnt_q;
  assign burst_valid  = burst_valid_q;
  assign burst_hdr    = burst_hdr_q;
  assign frame_done   = frame_done_q;
  assign frame_ok_cnt = frame_ok_q;
  assign fec_err_cnt  = fec_err_q;
  assign timeout_cnt  = timeout_q;

endmodule

// File: tb/tb_ul_frame_sequencer.sv
// Scoreboard bench for ul_frame_sequencer: stimulus tasks push expected
// burst/frame_done and data-burst msg_cnt values; a monitor pops them when
// the DUT presents burst_valid/frame_done or a payload deser_start.
module tb_ul_frame_sequencer;
  localparam int LW = 8;
  localparam int TW = 16;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst, enable;
  logic [TW-1:0] cfg_timeout;
  logic          train_start, train_done, deser_start, deser_hdr, deser_done;
  logic          fec_done, fec_uncor_err;
  logic [LW-1:0] hdr_len, msg_cnt;
  logic          burst_valid, burst_hdr, frame_done, lockout, busy;
  logic [SW-1:0] frame_ok_cnt, fec_err_cnt, timeout_cnt;

  always #5 clk = ~clk;

  ul_frame_sequencer #(
    .LEN_WIDTH(LW), .BURST_BYTES(7), .TO_WIDTH(TW), .STAT_WIDTH(SW), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_timeout(cfg_timeout),
    .train_start(train_start), .train_done(train_done),
    .deser_start(deser_start), .deser_hdr(deser_hdr), .deser_done(deser_done),
    .fec_done(fec_done), .fec_uncor_err(fec_uncor_err), .hdr_len(hdr_len),
    .msg_cnt(msg_cnt), .burst_valid(burst_valid), .burst_hdr(burst_hdr),
    .frame_done(frame_done), .lockout(lockout), .busy(busy),
    .frame_ok_cnt(frame_ok_cnt), .fec_err_cnt(fec_err_cnt), .timeout_cnt(timeout_cnt)
  );

  typedef struct packed { logic bv; logic hdr; logic fd; } burst_t;

  burst_t exp_b[$];
  int     exp_c[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents an output event.
  always @(negedge clk) begin : monitor
    burst_t b;
    int     c;
    if (!rst && (burst_valid || frame_done)) begin
      if (exp_b.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_burst: bv=%0d hdr=%0d fd=%0d with nothing expected",
                 burst_valid, burst_hdr, frame_done);
      end else begin
        b = exp_b.pop_front();
        check("burst_valid", int'(burst_valid), int'(b.bv));
        check("burst_hdr",   int'(burst_hdr),   int'(b.hdr));
        check("frame_done",  int'(frame_done),  int'(b.fd));
      end
    end
    if (!rst && deser_start && !deser_hdr) begin
      if (exp_c.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_data_start: msg_cnt=%0d with nothing expected", msg_cnt);
      end else begin
        c = exp_c.pop_front();
        check("msg_cnt", int'(msg_cnt), c);
      end
    end
  end

  task automatic wait_for(input int which, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if ((which == 0 && train_start) || (which == 1 && deser_start)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no pulse within 64 cycles", name);
    end
  endtask

  task automatic run_train();
    bit ok;
    wait_for(0, "train_start", ok);
    @(negedge clk); train_done = 1'b1;
    @(negedge clk); train_done = 1'b0;
  endtask

  task automatic hdr_phase(input bit err, input int len);
    bit ok;
    exp_b.push_back('{1'b1, 1'b1, 1'b0});
    if (!err && len == 0) exp_b.push_back('{1'b0, 1'b0, 1'b1});
    run_train();
    wait_for(1, "hdr_deser_start", ok);
    check("deser_hdr_hdr", int'(deser_hdr), 1);
    @(negedge clk); deser_done = 1'b1;
    @(negedge clk); deser_done = 1'b0;
    fec_done = 1'b1; fec_uncor_err = err; hdr_len = LW'(len);
    @(negedge clk); fec_done = 1'b0; fec_uncor_err = 1'b0;
  endtask

  task automatic data_phase(input int cnt, input bit last);
    bit ok;
    exp_c.push_back(cnt);
    exp_b.push_back('{1'b1, 1'b0, last});
    run_train();
    wait_for(1, "data_deser_start", ok);
    check("deser_hdr_data", int'(deser_hdr), 0);
    @(negedge clk); deser_done = 1'b1;
    @(negedge clk); deser_done = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_train_start"}, int'(train_start), 0);
    check({tag, "_deser_start"}, int'(deser_start), 0);
    check({tag, "_deser_hdr"},   int'(deser_hdr), 0);
    check({tag, "_msg_cnt"},     int'(msg_cnt), 0);
    check({tag, "_burst_valid"}, int'(burst_valid), 0);
    check({tag, "_burst_hdr"},   int'(burst_hdr), 0);
    check({tag, "_frame_done"},  int'(frame_done), 0);
    check({tag, "_lockout"},     int'(lockout), 0);
    check({tag, "_busy"},        int'(busy), 0);
    check({tag, "_frame_ok"},    int'(frame_ok_cnt), 0);
    check({tag, "_fec_err"},     int'(fec_err_cnt), 0);
    check({tag, "_timeout"},     int'(timeout_cnt), 0);
  endtask

  initial begin : guard
    #1_000_000;
    $display("FAIL global_time_limit: run did not finish");
    $fatal(1);
  end

  initial begin : stim
    bit ok;
    int n;
    rst = 1'b1; enable = 1'b0; cfg_timeout = '0;
    train_done = 1'b0; deser_done = 1'b0; fec_done = 1'b0; fec_uncor_err = 1'b0;
    hdr_len = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0; enable = 1'b1;

    // Nominal frame, length 20: 7, 14, 20
    hdr_phase(1'b0, 20);
    data_phase(7, 1'b0);
    data_phase(14, 1'b0);
    data_phase(20, 1'b1);
    check("nominal_frame_ok", int'(frame_ok_cnt), 1);
    check("nominal_msg_cnt_cleared", int'(msg_cnt), 0);

    // Zero-length header completes from FEC_WAIT
    hdr_phase(1'b0, 0);
    check("len0_frame_ok", int'(frame_ok_cnt), 2);
    check("len0_busy", int'(busy), 1);

    // Three uncorrectable headers -> lockout
    hdr_phase(1'b1, 0);
    hdr_phase(1'b1, 0);
    check("retry2_lockout", int'(lockout), 0);
    hdr_phase(1'b1, 0);
    check("retry3_lockout", int'(lockout), 1);
    check("retry3_busy", int'(busy), 0);
    check("retry3_fec_err", int'(fec_err_cnt), 3);
    repeat (5) @(negedge clk);
    check("lockout_sticky", int'(lockout), 1);
    check("lockout_no_train", int'(train_start), 0);
    enable = 1'b0;
    @(negedge clk);
    check("disable_lockout", int'(lockout), 0);
    check("disable_busy", int'(busy), 0);
    check("disable_fec_err_held", int'(fec_err_cnt), 3);
    check("disable_frame_ok_held", int'(frame_ok_cnt), 2);
    enable = 1'b1;

    // Watchdog expiry in DATA_WAIT
    cfg_timeout = 16'd10;
    hdr_phase(1'b0, 20);
    exp_c.push_back(7);
    run_train();
    wait_for(1, "to_deser_start", ok);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!train_start && n < 40);
    check("timeout_cycles", n, 11);
    check("timeout_cnt", int'(timeout_cnt), 1);
    check("timeout_msg_cnt", int'(msg_cnt), 0);

    // Done on the expiry cycle wins
    hdr_phase(1'b0, 20);
    exp_c.push_back(7);
    exp_b.push_back('{1'b1, 1'b0, 1'b0});
    run_train();
    wait_for(1, "race_deser_start", ok);
    repeat (10) @(negedge clk);
    deser_done = 1'b1;
    @(negedge clk); deser_done = 1'b0;
    check("race_timeout_cnt", int'(timeout_cnt), 1);
    cfg_timeout = '0;
    data_phase(14, 1'b0);
    data_phase(20, 1'b1);
    check("race_frame_ok", int'(frame_ok_cnt), 3);

    // Length 255: 7..252 then clamps to 255
    hdr_phase(1'b0, 255);
    for (int i = 1; i <= 36; i++) data_phase(7 * i, 1'b0);
    data_phase(255, 1'b1);
    check("len255_frame_ok", int'(frame_ok_cnt), 4);

    // Push frame count to 256 total: statistic holds at 255
    for (int i = 0; i < 252; i++) hdr_phase(1'b0, 0);
    check("frame_ok_saturated", int'(frame_ok_cnt), 255);

    // Reset in the middle of DATA_WAIT
    hdr_phase(1'b0, 20);
    exp_c.push_back(7);
    run_train();
    wait_for(1, "rst_deser_start", ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    hdr_phase(1'b0, 20);
    data_phase(7, 1'b0);
    data_phase(14, 1'b0);
    data_phase(20, 1'b1);
    check("post_rst_frame_ok", int'(frame_ok_cnt), 1);
    check("post_rst_timeout", int'(timeout_cnt), 0);

    repeat (3) @(negedge clk);
    check("burst_queue_drained", exp_b.size(), 0);
    check("cnt_queue_drained", exp_c.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
